mipi_csi_rx_raw_depacker_8b4lane: RTL and testbench

MIPI_CSI_RX_RAW_DEPACKER_8B4LANE -- requirements
Module: mipi_csi_rx_raw_depacker_8b4lane

---
 rtl/mipi_csi_pkg.sv | 39 +++
 rtl/mipi_csi_rx_raw_unpack_group.sv | 46 ++++
 rtl/mipi_csi_rx_raw_depacker_8b4lane.sv | 121 ++++++++++++
 tb/tb_mipi_csi_rx_raw_depacker_8b4lane.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_csi_pkg.sv
// Shared MIPI CSI-2 receive definitions: RAW format codes, group sizes and lane/pixel widths.
package mipi_csi_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned LANES     = 4;
  localparam int unsigned PIX_W     = 16;
  localparam int unsigned PIX_PER   = 4;
  localparam int unsigned GROUP_MAX = 7;
  localparam int unsigned BUF_BYTES = 10;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned FMT_W     = 3;

  typedef enum logic [FMT_W-1:0] {
    RAW8  = 3'd0,
    RAW10 = 3'd1,
    RAW12 = 3'd2,
    RAW14 = 3'd3
  } raw_fmt_e;

  // Bytes consumed per group of four pixels
  localparam logic [CNT_W-1:0] GS_RAW8  = 4'd4;
  localparam logic [CNT_W-1:0] GS_RAW10 = 4'd5;
  localparam logic [CNT_W-1:0] GS_RAW12 = 4'd6;
  localparam logic [CNT_W-1:0] GS_RAW14 = 4'd7;

  function automatic logic raw_fmt_supported(input logic [FMT_W-1:0] fmt);
    return fmt < 3'd4;
  endfunction

  function automatic logic [CNT_W-1:0] raw_group_size(input logic [FMT_W-1:0] fmt);
    case (fmt)
      RAW10:   return GS_RAW10;
      RAW12:   return GS_RAW12;
      RAW14:   return GS_RAW14;
      default: return GS_RAW8;
    endcase
  endfunction

endpackage

// File: rtl/mipi_csi_rx_raw_unpack_group.sv
// Combinational mapper from one packed RAW byte group (up to 7 bytes) to four 16-bit pixels.
module mipi_csi_rx_raw_unpack_group
  import mipi_csi_pkg::*;
(
  input  logic [GROUP_MAX*BYTE_W-1:0] bytes_i,
  input  logic [FMT_W-1:0]            fmt_i,
  output logic [PIX_PER*PIX_W-1:0]    pixels_c
);

  logic [BYTE_W-1:0] b [GROUP_MAX];

  always_comb begin
    for (int i = 0; i < int'(GROUP_MAX); i++) begin
      b[i] = bytes_i[i*BYTE_W +: BYTE_W];
    end
  end

  // Low-order bits live in the trailing byte(s) of each group; pixels are right-aligned
  always_comb begin
    pixels_c = '0;
    case (fmt_i)
      RAW8: begin
        for (int n = 0; n < int'(PIX_PER); n++) begin
          pixels_c[n*PIX_W +: PIX_W] = PIX_W'(b[n]);
        end
      end
      RAW10: begin
        for (int n = 0; n < int'(PIX_PER); n++) begin
          pixels_c[n*PIX_W +: PIX_W] = PIX_W'({b[n], b[4][2*n +: 2]});
        end
      end
      RAW12: begin
        pixels_c = {PIX_W'({b[4], b[5][7:4]}), PIX_W'({b[3], b[5][3:0]}),
                    PIX_W'({b[1], b[2][7:4]}), PIX_W'({b[0], b[2][3:0]})};
      end
      RAW14: begin
        pixels_c = {PIX_W'({b[3], b[6][7:2]}),
                    PIX_W'({b[2], b[6][1:0], b[5][7:4]}),
                    PIX_W'({b[1], b[5][3:0], b[4][7:6]}),
                    PIX_W'({b[0], b[4][5:0]})};
      end
      default: pixels_c = '0;
    endcase
  end

endmodule

// File: rtl/mipi_csi_rx_raw_depacker_8b4lane.sv
// RAW8/10/12/14 depacker for a 4-lane byte stream: accumulates payload bytes and emits 4 pixels per beat.
module mipi_csi_rx_raw_depacker_8b4lane
  import mipi_csi_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       data_valid_i,
  input  logic [LANES*BYTE_W-1:0]    data_i,
  input  logic [FMT_W-1:0]           packet_type_i,
  output logic                       output_valid_o,
  output logic [PIX_PER*PIX_W-1:0]   pixel_data_o,
  output logic                       line_start_o
);

  localparam int unsigned BUF_W = BUF_BYTES * BYTE_W;
  localparam int unsigned OUT_W = PIX_PER * PIX_W;

  // BLOCKED: waiting for a low valid cycle after reset; IDLE: armed for a packet start
  typedef enum logic [1:0] {ST_BLOCKED, ST_IDLE, ST_PACKET} state_e;

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FMT_W-1:0]   type_q, type_d;
  logic               first_q, first_d;
  logic               valid_q, valid_d;
  logic               ls_q, ls_d;
  logic [OUT_W-1:0]   pix_q, pix_d;

  logic [FMT_W-1:0]   fmt_c;
  logic [BUF_W-1:0]   merged_c;
  logic [CNT_W-1:0]   total_c;
  logic [CNT_W-1:0]   gs_c;
  logic [OUT_W-1:0]   group_pix_c;
  logic               accept_c;

  // The packet's first cycle decodes with the incoming type before it is latched
  always_comb begin
    fmt_c    = (state_q == ST_PACKET) ? type_q : packet_type_i;
    merged_c = buf_q | (BUF_W'(data_i) << {cnt_q, 3'b000});
    total_c  = cnt_q + CNT_W'(LANES);
    gs_c     = raw_group_size(fmt_c);
  end

  mipi_csi_rx_raw_unpack_group u_unpack (
    .bytes_i  (merged_c[GROUP_MAX*BYTE_W-1:0]),
    .fmt_i    (fmt_c),
    .pixels_c (group_pix_c)
  );

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    type_d   = type_q;
    first_d  = first_q;
    valid_d  = 1'b0;
    ls_d     = 1'b0;
    pix_d    = pix_q;
    accept_c = 1'b0;

    if (!data_valid_i) begin
      state_d = ST_IDLE;
      buf_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_PACKET;
          type_d   = packet_type_i;
          first_d  = 1'b1;
          accept_c = 1'b1;
        end
        ST_PACKET: accept_c = 1'b1;
        default:   accept_c = 1'b0;
      endcase

      // Unsupported formats never accumulate, so nothing is ever emitted for them
      if (accept_c && raw_fmt_supported(fmt_c)) begin
        if (total_c >= gs_c) begin
          valid_d = 1'b1;
          ls_d    = first_d;
          first_d = 1'b0;
          pix_d   = group_pix_c;
          buf_d   = merged_c >> {gs_c, 3'b000};
          cnt_d   = total_c - gs_c;
        end else begin
          buf_d   = merged_c;
          cnt_d   = total_c;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_BLOCKED;
      buf_q   <= '0;
      cnt_q   <= '0;
      type_q  <= '0;
      first_q <= 1'b0;
      valid_q <= 1'b0;
      ls_q    <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      first_q <= first_d;
      valid_q <= valid_d;
      ls_q    <= ls_d;
      pix_q   <= pix_d;
    end
  end

  assign output_valid_o = valid_q;
  assign line_start_o   = ls_q;
  assign pixel_data_o   = pix_q;

endmodule

// File: tb/tb_mipi_csi_rx_raw_depacker_8b4lane.sv
// Self-checking bench for the RAW depacker: directed table, corner sequences, and randomized packets vs a byte-queue model.
module tb_mipi_csi_rx_raw_depacker_8b4lane;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        data_valid_i;
  logic [31:0] data_i;
  logic [2:0]  packet_type_i;
  logic        output_valid_o;
  logic [63:0] pixel_data_o;
  logic        line_start_o;

  int checks   = 0;
  int failures = 0;
  int beats    = 0;

  always #5 clk = ~clk;

  mipi_csi_rx_raw_depacker_8b4lane dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .data_valid_i   (data_valid_i),
    .data_i         (data_i),
    .packet_type_i  (packet_type_i),
    .output_valid_o (output_valid_o),
    .pixel_data_o   (pixel_data_o),
    .line_start_o   (line_start_o)
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic [2:0]  t;
    logic [31:0] d;
    logic        ev;
    logic        els;
    logic [63:0] epix;
  } vec_t;

  vec_t vecs[10];

  // Reference model state
  int          m_state;   // 0 blocked after reset, 1 armed, 2 inside packet
  logic [7:0]  mq[$];
  logic [2:0]  m_type;
  bit          m_first;
  logic        exp_valid;
  logic        exp_ls;
  logic [63:0] exp_pix;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_unpack(input int unsigned b[7], input logic [2:0] t);
    int unsigned p[4];
    for (int n = 0; n < 4; n++) p[n] = 0;
    case (t)
      3'd0: for (int n = 0; n < 4; n++) p[n] = b[n];
      3'd1: for (int n = 0; n < 4; n++) p[n] = b[n] * 4 + ((b[4] >> (2 * n)) & 3);
      3'd2: begin
        p[0] = b[0] * 16 + (b[2] & 15);
        p[1] = b[1] * 16 + (b[2] >> 4);
        p[2] = b[3] * 16 + (b[5] & 15);
        p[3] = b[4] * 16 + (b[5] >> 4);
      end
      3'd3: begin
        p[0] = b[0] * 64 + (b[4] & 63);
        p[1] = b[1] * 64 + (b[5] & 15) * 4 + (b[4] >> 6);
        p[2] = b[2] * 64 + (b[6] & 3) * 16 + (b[5] >> 4);
        p[3] = b[3] * 64 + (b[6] >> 2);
      end
      default: ;
    endcase
    return {16'(p[3]), 16'(p[2]), 16'(p[1]), 16'(p[0])};
  endfunction

  function automatic void model(input logic rst, input logic v, input logic [2:0] t,
                                input logic [31:0] d);
    int unsigned b[7];
    int gs;
    exp_valid = 1'b0;
    exp_ls    = 1'b0;
    if (rst) begin
      mq.delete();
      m_state = 0;
      exp_pix = '0;
      return;
    end
    if (!v) begin
      mq.delete();
      m_state = 1;
      return;
    end
    if (m_state == 1) begin
      m_state = 2;
      m_type  = t;
      m_first = 1'b1;
      mq.delete();
    end
    if (m_state != 2 || m_type > 3'd3) return;
    for (int i = 0; i < 4; i++) mq.push_back(d[8*i +: 8]);
    gs = 4 + int'(m_type);
    if (mq.size() >= gs) begin
      for (int i = 0; i < 7; i++) b[i] = (i < mq.size()) ? int'(mq[i]) : 0;
      exp_pix   = ref_unpack(b, m_type);
      exp_valid = 1'b1;
      exp_ls    = m_first;
      m_first   = 1'b0;
      for (int i = 0; i < gs; i++) void'(mq.pop_front());
    end
  endfunction

  task automatic step(input logic rst, input logic v, input logic [2:0] t, input logic [31:0] d);
    reset_i       = rst;
    data_valid_i  = v;
    packet_type_i = t;
    data_i        = d;
    model(rst, v, t, d);
    @(posedge clk);
    #1;
    check("output_valid", 64'(output_valid_o), 64'(exp_valid));
    check("line_start",   64'(line_start_o),   64'(exp_ls));
    check("pixel_data",   pixel_data_o,        exp_pix);
    if (output_valid_o) beats++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom);
  endtask

  task automatic pkt(input logic [2:0] t, input int n);
    beats = 0;
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, t, $urandom);
    idle();
  endtask

  initial begin
    reset_i       = 1'b1;
    data_valid_i  = 1'b0;
    data_i        = '0;
    packet_type_i = '0;

    vecs[0] = '{1'b1, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 64'h0};
    vecs[1] = '{1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 64'h0};
    vecs[2] = '{1'b0, 1'b1, 3'd0, 32'hDDCCBBAA, 1'b1, 1'b1, 64'h00DD_00CC_00BB_00AA};
    vecs[3] = '{1'b0, 1'b1, 3'd0, 32'h44332211, 1'b1, 1'b0, 64'h0044_0033_0022_0011};
    vecs[4] = '{1'b0, 1'b0, 3'd1, 32'h0,        1'b0, 1'b0, 64'h0044_0033_0022_0011};
    vecs[5] = '{1'b0, 1'b1, 3'd1, 32'h44332211, 1'b0, 1'b0, 64'h0044_0033_0022_0011};
    vecs[6] = '{1'b0, 1'b1, 3'd1, 32'h998877E4, 1'b1, 1'b1, 64'h0113_00CE_0089_0044};
    vecs[7] = '{1'b0, 1'b0, 3'd1, 32'h0,        1'b0, 1'b0, 64'h0113_00CE_0089_0044};
    vecs[8] = '{1'b0, 1'b1, 3'd1, 32'h44332211, 1'b0, 1'b0, 64'h0113_00CE_0089_0044};
    vecs[9] = '{1'b0, 1'b1, 3'd1, 32'h000000E4, 1'b1, 1'b1, 64'h0113_00CE_0089_0044};

    for (int i = 0; i < 10; i++) begin
      reset_i       = vecs[i].rst;
      data_valid_i  = vecs[i].v;
      packet_type_i = vecs[i].t;
      data_i        = vecs[i].d;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), 64'(output_valid_o), 64'(vecs[i].ev));
      check($sformatf("vec%0d_ls", i),    64'(line_start_o),   64'(vecs[i].els));
      check($sformatf("vec%0d_pix", i),   pixel_data_o,        vecs[i].epix);
    end

    // Model-checked phase starts from a fresh reset
    step(1'b1, 1'b0, 3'd0, 32'h0);
    idle();

    pkt(3'd1, 20);
    check("raw10_beats", 64'(beats), 64'd16);

    beats = 0;
    step(1'b0, 1'b1, 3'd2, 32'hAB21CDAB);
    step(1'b0, 1'b1, 3'd2, {$urandom_range(0, 65535), 16'h21CD} );
    check("raw12_first_beat", pixel_data_o, 64'h0CD2_0AB1_0CD2_0AB1);
    for (int i = 0; i < 302; i++) step(1'b0, 1'b1, 3'd2, $urandom);
    idle();
    check("raw12_beats", 64'(beats), 64'd202);

    beats = 0;
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 3'd3, 32'hFFFFFFFF);
    idle();
    check("raw14_pix", pixel_data_o, 64'h3FFF_3FFF_3FFF_3FFF);
    check("raw14_beats", 64'(beats), 64'd4);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd1, $urandom);
    step(1'b1, 1'b1, 3'd1, $urandom);
    beats = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 3'd1, $urandom);
    check("post_reset_beats", 64'(beats), 64'd0);
    idle();
    pkt(3'd1, 10);
    check("raw10_after_reset_beats", 64'(beats), 64'd8);

    pkt(3'd5, 8);
    check("unsupported_beats", 64'(beats), 64'd0);
    pkt(3'd1, 5);
    check("raw10_after_unsup_beats", 64'(beats), 64'd4);

    for (int p = 0; p < 60; p++) begin
      logic [2:0] t;
      int n;
      t = 3'($urandom_range(0, 7));
      n = $urandom_range(1, 25);
      for (int i = 0; i < n; i++) begin
        step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, 1'b1, t, $urandom);
      end
      for (int g = $urandom_range(1, 3); g > 0; g--) idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
